prog_loader16: RTL and testbench

Boot-time program loader for the 16-bit-instruction CPU. It accepts a framed byte stream on a valid/ready interface and assembles big-endian 16-bit instruction words (opcode[15:12], reg_dst[11:10], reg_src[9:8], imm8[7:0]). It writes the words into instruction memory from address 0 upward, verifies a checksum, and holds the CPU core in reset until a frame has loaded cleanly. It is the producer side of the control decoder: everything the decoder fetches is placed by this block.

---
 rtl/prog_loader_pkg.sv | 27 ++
 rtl/loader_timeout.sv | 25 ++
 rtl/prog_loader16.sv | 153 +++++++++++++++
 tb/tb_prog_loader16.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared loader/decoder definitions: FSM states, default frame marker, instruction field positions.
// Combinational constants only; no latency, no flow control.
// Field positions must match the control decoder that fetches what the loader writes.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 10;
    localparam int SRC_MSB = 9;
    localparam int SRC_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for the loader: counts enabled cycles without a clear.
// expired is combinational, asserted during the limit-th consecutive idle cycle.
// No flow control; limit of 0 disables expiry.
module loader_timeout (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] cnt;

    assign expired = enable && !clear && (limit != 16'd0) && (cnt == limit - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || clear || expired) begin
            cnt <= 16'd0;
        end else if (enable) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/prog_loader16.sv
// Boot loader: framed byte stream -> big-endian 16-bit words in imem, checksum-gated CPU release.
// Write strobe 1 cycle after the low byte; done/hold-release 1 cycle after the checksum byte.
// Always ready, one byte per cycle sustained; no back-pressure toward the source.
module prog_loader16
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [8:0]  loaded_count
);

    state_t      state, state_nxt;
    logic [7:0]  hi_q;
    logic [7:0]  idx;
    logic [7:0]  sum;
    logic [8:0]  n_words;
    logic        hold_q;
    logic        err_q;
    logic        acc;
    logic        is_sync;
    logic        in_frame;
    logic        tmo_expired;
    logic        last_word;
    logic        word_wr;
    logic        done_set;
    logic        err_set;
    logic        restart;

    assign in_ready  = 1'b1;
    assign acc       = in_valid;
    assign is_sync   = (in_data == SYNC_BYTE);
    assign in_frame  = (state == ST_LEN) || (state == ST_HI) || (state == ST_LO) || (state == ST_CSUM);
    assign last_word = ({1'b0, idx} + 9'd1) == n_words;

    loader_timeout u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc || !in_frame),
        .enable  (in_frame),
        .limit   (TIMEOUT),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        word_wr   = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        restart   = 1'b0;
        case (state)
            ST_IDLE: if (acc && is_sync) state_nxt = ST_LEN;
            ST_LEN:  if (acc) state_nxt = ST_HI;
            ST_HI:   if (acc) state_nxt = ST_LO;
            ST_LO: begin
                if (acc) begin
                    word_wr   = 1'b1;
                    state_nxt = last_word ? ST_CSUM : ST_HI;
                end
            end
            ST_CSUM: begin
                if (acc) begin
                    done_set  = (in_data == sum);
                    err_set   = (in_data != sum);
                    state_nxt = (in_data == sum) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (acc && is_sync) begin
                    restart   = 1'b1;
                    state_nxt = ST_LEN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (tmo_expired) begin
            err_set   = 1'b1;
            state_nxt = ST_ERR;
        end
    end

    // The CPU must be held from the very cycle a restart SYNC is presented.
    assign cpu_hold = hold_q | restart;
    assign err      = err_q & ~restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we      <= 1'b0;
            imem_addr    <= 8'd0;
            imem_wdata   <= 16'd0;
            loaded_count <= 9'd0;
            hold_q       <= 1'b1;
            err_q        <= 1'b0;
            done         <= 1'b0;
            hi_q         <= 8'd0;
            idx          <= 8'd0;
            sum          <= 8'd0;
            n_words      <= 9'd0;
        end else begin
            imem_we <= word_wr;
            done    <= done_set;
            if (state == ST_LEN && acc) begin
                n_words <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                idx     <= 8'd0;
                sum     <= in_data;
            end
            if ((state == ST_HI || state == ST_LO) && acc) begin
                sum <= sum + in_data;
            end
            if (state == ST_HI && acc) begin
                hi_q <= in_data;
            end
            if (word_wr) begin
                imem_addr    <= idx;
                imem_wdata   <= {hi_q, in_data};
                idx          <= idx + 8'd1;
                loaded_count <= {1'b0, idx} + 9'd1;
            end
            if (done_set) begin
                hold_q <= 1'b0;
            end
            if (err_set) begin
                err_q  <= 1'b1;
                hold_q <= 1'b1;
            end
            if (restart) begin
                err_q        <= 1'b0;
                hold_q       <= 1'b1;
                loaded_count <= 9'd0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader16.sv
// Directed bench for prog_loader16: good/bad frames, 256-word frame, noise, timeout, mid-frame reset.
module tb_prog_loader16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [8:0]  loaded_count;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [7:0] last_addr = 8'd0;

    prog_loader16 #(.SYNC_BYTE(8'hA5), .TIMEOUT(16'd10)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .loaded_count (loaded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= imem_addr;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_we"},    imem_we, 0);
        check_val({tag, "_addr"},  imem_addr, 0);
        check_val({tag, "_wdata"}, imem_wdata, 0);
        check_val({tag, "_hold"},  cpu_hold, 1);
        check_val({tag, "_done"},  done, 0);
        check_val({tag, "_err"},   err, 0);
        check_val({tag, "_cnt"},   loaded_count, 0);
        check_val({tag, "_rdy"},   in_ready, 1);
    endtask

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        idle(2);
        do_reset();
        check_reset_outputs("rst");

        // Good frame A5 02 10 05 21 03 3B
        send(8'hA5); send(8'h02); send(8'h10); send(8'h05);
        check_val("w0_we", imem_we, 1);
        check_val("w0_addr", imem_addr, 8'h00);
        check_val("w0_data", imem_wdata, 16'h1005);
        check_val("w0_cnt", loaded_count, 1);
        send(8'h21); send(8'h03);
        check_val("w1_we", imem_we, 1);
        check_val("w1_addr", imem_addr, 8'h01);
        check_val("w1_data", imem_wdata, 16'h2103);
        check_val("w1_cnt", loaded_count, 2);
        check_val("w1_hold", cpu_hold, 1);
        send(8'h3B);
        check_val("good_done", done, 1);
        check_val("good_hold", cpu_hold, 0);
        check_val("good_err", err, 0);
        idle(1);
        check_val("good_done_pulse", done, 0);
        check_val("good_hold_low", cpu_hold, 0);
        check_val("good_cnt", loaded_count, 2);

        // Bad checksum, restart from DONE; hold must rise with the SYNC itself
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        check_val("sync_hold_same_cycle", cpu_hold, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("sync_cnt_clear", loaded_count, 0);
        done_cnt = 0;
        send(8'h02); send(8'h10); send(8'h05); send(8'h21); send(8'h03); send(8'h3C);
        check_val("bad_err", err, 1);
        check_val("bad_hold", cpu_hold, 1);
        check_val("bad_done", done, 0);
        idle(3);
        check_val("bad_err_sticky", err, 1);
        check_val("bad_no_done", done_cnt, 0);
        send(8'hA5);
        check_val("resync_err_clear", err, 0);
        send(8'h02); send(8'h10); send(8'h05); send(8'h21); send(8'h03); send(8'h3B);
        check_val("resync_done", done, 1);
        check_val("resync_hold", cpu_hold, 0);

        // LEN 0 -> 256 words of zeros
        idle(1);
        wr_cnt = 0;
        send(8'hA5); send(8'h00);
        for (int i = 0; i < 512; i++) send(8'h00);
        check_val("big_cnt", loaded_count, 256);
        send(8'h00);
        check_val("big_done", done, 1);
        idle(1);
        check_val("big_writes", wr_cnt, 256);
        check_val("big_last_addr", last_addr, 8'hFF);

        // Noise and in-frame SYNC from IDLE: sum = 01+A5+A5 = 4B
        do_reset();
        wr_cnt = 0;
        send(8'h00); send(8'hFF);
        check_val("noise_no_write", imem_we, 0);
        send(8'hA5); send(8'h01); send(8'hA5); send(8'hA5);
        check_val("noise_addr", imem_addr, 8'h00);
        check_val("noise_data", imem_wdata, 16'hA5A5);
        send(8'h4B);
        check_val("noise_done", done, 1);
        idle(1);
        check_val("noise_writes", wr_cnt, 1);

        // Timeout of 10 idle cycles inside a frame
        wr_cnt = 0;
        send(8'hA5); send(8'h03); send(8'h12);
        idle(9);
        check_val("tmo_before", err, 0);
        idle(1);
        check_val("tmo_err", err, 1);
        check_val("tmo_hold", cpu_hold, 1);
        idle(1);
        check_val("tmo_no_write", wr_cnt, 0);

        // Reset between HI and LO of word 1
        wr_cnt = 0;
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h33);
        do_reset();
        check_reset_outputs("midrst");
        send(8'h44);
        idle(1);
        check_val("midrst_writes", wr_cnt, 1);
        send(8'hA5); send(8'h01); send(8'h12); send(8'h34); send(8'h47);
        check_val("after_rst_done", done, 1);
        check_val("after_rst_cnt", loaded_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
